inst_rom_server: RTL

//  Responder end of the CPU instruction-fetch interface: serves rom_ce/rom_addr fetches from an on-chip word array.

---
 rtl/inst_rom_server.sv | 101 ++++++++++
 1 files changed

// File: rtl/inst_rom_server.sv
// inst_rom_server: instruction word array with a valid/ready image loader.
// Fetch latency: zero. rom_data_o is combinational from rom_addr_i. Load beats write one word per cycle.
// Backpressure: ld_ready_o is high only while loading. The core is held idle (cpu_run_o=0) until the image completes.
module inst_rom_server #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              cpu_run_o,
  output logic [ADDR_W:0]   load_cnt_o,
  output logic              err_o
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;       // write pointer; doubles as the valid-word count
  logic              r_ld_ready;
  logic              r_cpu_run;
  logic              r_err;
  logic [31:0]       r_mem [0:DEPTH-1];

  logic [ADDR_W-1:0] w_idx;
  logic              w_aligned;
  logic              w_in_range;
  logic              w_loaded;
  logic              w_fetch_ok;
  logic              w_fetch_err;
  logic              w_beat;

  assign w_idx       = rom_addr_i[ADDR_W+1:2];
  assign w_aligned   = (rom_addr_i[1:0] == 2'b00);
  assign w_in_range  = (rom_addr_i[31:ADDR_W+2] == '0);
  assign w_loaded    = ({1'b0, w_idx} < r_cnt);
  assign w_fetch_ok  = rom_ce_i & r_cpu_run & w_aligned & w_in_range & w_loaded;
  assign w_fetch_err = rom_ce_i & r_cpu_run & ~(w_aligned & w_in_range);
  // A start pulse restarts the image, so a beat on that same cycle is discarded.
  assign w_beat      = r_ld_ready & ld_valid_i & ~ld_start_i;

  assign rom_data_o  = w_fetch_ok ? r_mem[w_idx] : 32'h0;
  assign ld_ready_o  = r_ld_ready;
  assign cpu_run_o   = r_cpu_run;
  assign load_cnt_o  = r_cnt;
  assign err_o       = r_err;

  // Image storage: written only by accepted loader beats, never reset.
  always_ff @(posedge clk) begin
    if (w_beat) r_mem[r_cnt[ADDR_W-1:0]] <= ld_data_i;
  end

  // Loader/run FSM with registered status outputs and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ld_ready <= 1'b0;
      r_cpu_run  <= 1'b0;
      r_err      <= 1'b0;
    end else if (ld_start_i) begin
      r_state    <= S_LOAD;
      r_cnt      <= '0;
      r_ld_ready <= 1'b1;
      r_cpu_run  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_beat) begin
            r_cnt <= r_cnt + ONE;
            // Last word, or the array just filled: stop accepting and release the core.
            if (ld_last_i || (r_cnt == LAST_IDX)) begin
              r_state    <= S_RUN;
              r_ld_ready <= 1'b0;
              r_cpu_run  <= 1'b1;
              if (!ld_last_i) r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_fetch_err) r_err <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
